// File: rtl/uart_word_tx_if.sv
// Word-level handshake and serial line bundle for uart_word_tx.
// The datapath side uses master; the transmitter uses slave.
interface uart_word_tx_if #(
  parameter int unsigned DATA_W = 64
) ();

  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    output start,
    output data_in,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  data_in,
    output tx,
    output busy,
    output done
  );

endinterface

// File: rtl/uart_word_tx.sv
// Parametrised UART word transmitter: serialises a DATA_W-bit word as DATA_W/8
// contiguous frames (start, 8 data LSB first, optional parity, 1-2 stop bits).
module uart_word_tx #(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned BAUD           = 115200,
  parameter int unsigned PARITY         = 0,
  parameter int unsigned STOP_BITS      = 1,
  parameter bit          MSB_BYTE_FIRST = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  uart_word_tx_if.slave bus
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned NBYTES   = DATA_W / 8;
  localparam int unsigned BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned BYTE_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);
  localparam bit                HAS_PAR   = (PARITY != 0);
  localparam bit                ODD_PAR   = (PARITY == 1);
  localparam bit                TWO_STOP  = (STOP_BITS == 2);

  if ((DATA_W < 8) || ((DATA_W % 8) != 0)) begin : gen_bad_data_w
    $error("uart_word_tx: DATA_W must be a multiple of 8 and at least 8");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : gen_bad_stop_bits
    $error("uart_word_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY > 2) begin : gen_bad_parity
    $error("uart_word_tx: PARITY must be 0, 1 or 2");
  end
  if (BAUD_DIV < 2) begin : gen_bad_baud_div
    $error("uart_word_tx: CLK_FREQ/BAUD must be at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic              stop_q, stop_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              tx_q, tx_d;
  logic              baud_last;
  logic [7:0]        cur_byte;

  // Byte slot for a given byte counter value, honouring the configured order.
  function automatic logic [7:0] pick_byte(logic [DATA_W-1:0] w, logic [BYTE_W-1:0] idx);
    int unsigned slot;
    logic [7:0]  b;
    slot = MSB_BYTE_FIRST ? (NBYTES - 1 - 32'(idx)) : 32'(idx);
    b    = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (slot == i) b = w[i*8 +: 8];
    end
    return b;
  endfunction

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    byte_d    = byte_q;
    word_d    = word_q;
    baud_last = (baud_q == BAUD_LAST);

    // Every bit-holding state advances the baud counter; it wraps exactly when
    // the state is left, so each entry starts from zero.
    if ((state_q != StIdle) && (state_q != StDone)) begin
      baud_d = baud_last ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          state_d = StStart;
          word_d  = bus.data_in;
          baud_d  = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          byte_d  = '0;
        end
      end
      StStart: begin
        if (baud_last) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            state_d = HAS_PAR ? StParity : StStop;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (baud_last) begin
          state_d = StStop;
          stop_d  = 1'b0;
        end
      end
      StStop: begin
        if (baud_last) begin
          if (TWO_STOP && !stop_q) begin
            stop_d = 1'b1;
          end else if (byte_q == BYTE_LAST) begin
            state_d = StDone;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = StStart;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // tx is registered from the next state so the pin never sees decode glitches.
    cur_byte = pick_byte(word_d, byte_d);
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = cur_byte[bit_d];
      StParity: tx_d = (^cur_byte) ^ ODD_PAR;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      byte_q  <= '0;
      word_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = (state_q != StIdle) && (state_q != StDone);
  assign bus.done = (state_q == StDone);

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: three configurations checked cycle by
// cycle against a frame-level reference model.
module tb_uart_word_tx;

  localparam int DIV = 10;

  logic        clk;
  logic        rst;
  logic        start_v;
  logic [63:0] data_v;
  int          sel;
  logic        tx_m, busy_m, done_m;
  int          n_cmp;
  int          n_err;

  int cfg_par  [3] = '{0, 1, 2};
  int cfg_stop [3] = '{1, 2, 1};
  int cfg_msb  [3] = '{0, 0, 1};
  int cfg_nb   [3] = '{8, 8, 2};

  typedef struct {
    int          s;
    logic [63:0] word;
    int          exp_done;
  } vec_t;

  vec_t vecs [5];

  uart_word_tx_if #(.DATA_W(64)) if_a ();
  uart_word_tx_if #(.DATA_W(64)) if_b ();
  uart_word_tx_if #(.DATA_W(16)) if_c ();

  assign if_a.start   = start_v && (sel == 0);
  assign if_b.start   = start_v && (sel == 1);
  assign if_c.start   = start_v && (sel == 2);
  assign if_a.data_in = data_v;
  assign if_b.data_in = data_v;
  assign if_c.data_in = data_v[15:0];

  uart_word_tx #(
    .DATA_W(64), .CLK_FREQ(1_000_000), .BAUD(100_000),
    .PARITY(0), .STOP_BITS(1), .MSB_BYTE_FIRST(1'b0)
  ) dut_a (.clk(clk), .rst_n(rst), .bus(if_a));

  uart_word_tx #(
    .DATA_W(64), .CLK_FREQ(1_000_000), .BAUD(100_000),
    .PARITY(1), .STOP_BITS(2), .MSB_BYTE_FIRST(1'b0)
  ) dut_b (.clk(clk), .rst_n(rst), .bus(if_b));

  uart_word_tx #(
    .DATA_W(16), .CLK_FREQ(1_000_000), .BAUD(100_000),
    .PARITY(2), .STOP_BITS(1), .MSB_BYTE_FIRST(1'b1)
  ) dut_c (.clk(clk), .rst_n(rst), .bus(if_c));

  always_comb begin
    tx_m   = 1'b1;
    busy_m = 1'b0;
    done_m = 1'b0;
    case (sel)
      0: begin tx_m = if_a.tx; busy_m = if_a.busy; done_m = if_a.done; end
      1: begin tx_m = if_b.tx; busy_m = if_b.busy; done_m = if_b.done; end
      2: begin tx_m = if_c.tx; busy_m = if_c.busy; done_m = if_c.done; end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (sel=%0d t=%0t): got %0h, expected %0h", name, sel, $time, act, exp);
    end
  endtask

  function automatic int frame_bits(input int s);
    return 10 + ((cfg_par[s] != 0) ? 1 : 0) + (cfg_stop[s] - 1);
  endfunction

  // Expected line level k cycles after acceptance (k=1 is the first start-bit cycle).
  function automatic logic exp_tx(input int s, input logic [63:0] w, input int k);
    int          idx, b, p, bi, ones;
    logic [63:0] sh;
    logic [7:0]  by;
    if (k < 1) return 1'b1;
    idx = (k - 1) / DIV;
    if (idx >= cfg_nb[s] * frame_bits(s)) return 1'b1;
    b  = idx / frame_bits(s);
    p  = idx % frame_bits(s);
    bi = (cfg_msb[s] != 0) ? (cfg_nb[s] - 1 - b) : b;
    sh = w >> (8 * bi);
    by = sh[7:0];
    if (p == 0) return 1'b0;
    if (p <= 8) return by[p-1];
    if ((p == 9) && (cfg_par[s] != 0)) begin
      ones = $countones(by);
      return (cfg_par[s] == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    end
    return 1'b1;
  endfunction

  // Sends one word and checks every cycle up to and including the done cycle.
  // pre: start/data already driven; hold: keep start high and present nxt at done.
  task automatic run_word(input int s, input logic [63:0] w, input bit pre, input bit hold,
                          input bit noise, input logic [63:0] nxt, input int exp_done);
    if (!pre) begin
      @(negedge clk);
      sel     = s;
      data_v  = w;
      start_v = 1'b1;
      #1;
    end
    chk("busy_before_accept", 64'(busy_m), 64'(0));
    @(posedge clk);
    #1;
    if (!hold) start_v = 1'b0;
    for (int k = 1; k <= exp_done; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (k < exp_done) begin
        chk($sformatf("tx[k=%0d]", k), 64'(tx_m), 64'(exp_tx(s, w, k)));
        chk($sformatf("busy[k=%0d]", k), 64'(busy_m), 64'(1));
        chk($sformatf("done[k=%0d]", k), 64'(done_m), 64'(0));
        if (noise) begin
          data_v = {$urandom, $urandom};
          if (!hold) start_v = 1'($urandom_range(0, 1));
        end
      end else begin
        chk("done_pulse", 64'(done_m), 64'(1));
        chk("busy_at_done", 64'(busy_m), 64'(0));
        chk("tx_at_done", 64'(tx_m), 64'(1));
        if (hold) data_v = nxt;
        else start_v = 1'b0;
      end
    end
    if (!hold) begin
      @(posedge clk);
      #1;
      chk("done_single", 64'(done_m), 64'(0));
      chk("busy_after_done", 64'(busy_m), 64'(0));
      chk("tx_idle", 64'(tx_m), 64'(1));
    end
  endtask

  initial begin
    logic [63:0] w;
    int          s;
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    start_v = 1'b0;
    data_v  = '0;
    sel     = 0;

    vecs[0] = '{0, 64'h2d7e66091ed0a403, 801};
    vecs[1] = '{1, 64'h2d7e66091ed0a403, 961};
    vecs[2] = '{2, 64'h000000000000d253, 221};
    vecs[3] = '{0, 64'hd253328dd2c0fc3c, 801};
    vecs[4] = '{2, 64'h00000000000000ff, 221};

    // Reset state, with start asserted during reset (reset must win).
    repeat (2) @(posedge clk);
    @(negedge clk);
    start_v = 1'b1;
    data_v  = 64'h0123456789abcdef;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      chk("reset_tx", 64'(tx_m), 64'(1));
      chk("reset_busy", 64'(busy_m), 64'(0));
      chk("reset_done", 64'(done_m), 64'(0));
    end
    @(negedge clk);
    start_v = 1'b0;
    rst     = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_word(vecs[i].s, vecs[i].word, 1'b0, 1'b0, 1'b0, 64'h0, vecs[i].exp_done);
    end

    // Back-to-back words with start held high; data switched during done.
    run_word(0, 64'hd253328dd2c0fc3c, 1'b0, 1'b1, 1'b1, 64'h8162476652bdd1d0, 801);
    run_word(0, 64'h8162476652bdd1d0, 1'b1, 1'b0, 1'b0, 64'h0, 801);

    // Reset during byte 3, data bit 4: line and busy drop at once, no done.
    w = 64'h2d7e66091ed0a403;
    @(negedge clk);
    sel     = 0;
    data_v  = w;
    start_v = 1'b1;
    @(posedge clk);
    #1;
    start_v = 1'b0;
    repeat (355) @(posedge clk);
    #3;
    chk("pre_reset_tx", 64'(tx_m), 64'(exp_tx(0, w, 356)));
    chk("pre_reset_busy", 64'(busy_m), 64'(1));
    rst = 1'b1;
    #1;
    chk("async_reset_tx", 64'(tx_m), 64'(1));
    chk("async_reset_busy", 64'(busy_m), 64'(0));
    chk("async_reset_done", 64'(done_m), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("in_reset_done", 64'(done_m), 64'(0));
      chk("in_reset_tx", 64'(tx_m), 64'(1));
    end
    @(negedge clk);
    rst = 1'b0;
    run_word(0, w, 1'b0, 1'b0, 1'b0, 64'h0, 801);

    // Random words on random configurations, with start pulses and data churn mid-word.
    for (int i = 0; i < 6; i++) begin
      s = int'($urandom_range(0, 2));
      w = {$urandom, $urandom};
      run_word(s, w, 1'b0, 1'b0, 1'b1, 64'h0, cfg_nb[s] * frame_bits(s) * DIV + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- Parametrised UART word transmitter: accepts a DATA_W-bit word and serialises it on one TX line as DATA_W/8 back-to-back UART frames.
- Supersedes the fixed 64-bit, 8N1, LSB-byte-first transmit path. Adds configurable width, baud divisor, parity, stop bits and byte order, plus an explicit busy/done handshake.
- Sits between the word-level datapath and the board TX pin.

Parameters:
- DATA_W, 64, word width in bits; must be a multiple of 8 and ≥ 8.
- CLK_FREQ, 50_000_000, clk frequency in Hz.
- BAUD, 115200, line rate. BAUD_DIV = CLK_FREQ/BAUD (integer division) = clk cycles per bit; must be ≥ 2.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame: 1 or 2.
- MSB_BYTE_FIRST, 0, byte order: 0 sends data_in[7:0] first; 1 sends data_in[DATA_W-1:DATA_W-8] first.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-high (1 = reset).
- start  in  1  request to send; sampled on every rising clk edge.
- data_in  in  DATA_W  word to send; captured on acceptance.
- tx  out  1  serial line; idles high.
- busy  out  1  high while a word is in flight.
- done  out  1  one-cycle pulse at end of word.

Behaviour:
- Reset values: tx=1, busy=0, done=0, FSM=IDLE, all counters 0. Reset applies immediately and asynchronously.
- Reset mid-word aborts the word: tx returns high at once and no done pulse is produced.
- Acceptance: start=1 && busy=0 at an edge latches data_in into a shift register.
  - busy=1 from the next cycle.
  - start is ignored while busy=1 (level or pulse; no queuing).
  - data_in changes after acceptance have no effect.
- FSM states and transitions:
  - IDLE → START on acceptance.
  - START → DATA.
  - DATA → PARITY (if PARITY≠0), otherwise → STOP.
  - PARITY → STOP.
  - STOP → START if bytes remain, otherwise → DONE.
  - DONE → IDLE.
- Bit timing: each bit is held exactly BAUD_DIV cycles, counted by a baud counter that runs 0..BAUD_DIV-1. The counter restarts at each state entry.
- Frame format: start bit 0; 8 data bits LSB first; optional parity bit; then STOP_BITS stop bits of value 1. Frames are contiguous, with no idle gap between bytes.
- Parity is computed over the 8 data bits only:
  - odd: bit makes the total count of ones odd.
  - even: bit makes the total count of ones even.
- Byte counter runs 0..DATA_W/8-1; byte selection follows MSB_BYTE_FIRST.
- Latency: tx falls on the first cycle after acceptance. FRAME = 10 + (PARITY≠0) + (STOP_BITS-1) bits.
  - Last stop bit ends NBYTES*FRAME*BAUD_DIV cycles after tx falls.
  - On the following cycle (DONE state) done=1 and busy=0 together; then DONE → IDLE.
- Back-to-back words: start=1 during the done cycle is accepted, since busy=0 in that cycle. The next start bit begins one cycle later, so there is no extra idle time on the line.
- Simultaneous rst_n=1 and start=1: reset wins.
- Elaboration check: an illegal DATA_W, STOP_BITS, PARITY or BAUD_DIV<2 shall stop elaboration ($error inside a generate guard).

Test Plan:
- Defaults scaled to CLK_FREQ=1_000_000, BAUD=100_000 (BAUD_DIV=10), 8N1, DATA_W=64. Send 64'h2d7e66091ed0a403.
  - Required: first frame on tx = 0,1,1,0,0,0,0,0,0,1 (byte 0x03), each bit 10 cycles.
  - Byte order 03,a4,d0,1e,09,66,7e,2d.
  - done pulses exactly 801 cycles after acceptance with busy falling in that cycle.
- PARITY=1, STOP_BITS=2, same word. Byte 0x03 gives parity bit 1 and byte 0xa4 gives parity bit 0. Each frame is 12 bits; done at 961 cycles.
- PARITY=2, MSB_BYTE_FIRST=1, DATA_W=16, data 16'hd253.
  - First byte 0xd2 with even parity bit 0, then 0x53 with parity 0.
  - done at 2*11*10+1 = 221 cycles.
- Hold start=1 continuously with data 64'hd253328dd2c0fc3c then 64'h8162476652bdd1d0, switched at done.
  - Required: second word starts one cycle after done, with no extra idle between stop and start bit.
  - start is ignored mid-word and data_in changes mid-word do not alter tx.
- Assert rst_n=1 during byte 3 data bit 4. Required: tx=1 and busy=0 asynchronously, no done pulse.
  - After release, a new start transmits the full word from byte 0.
- start pulsed for one cycle while busy=1 → no effect: frame count stays 8 and exactly one done pulse is produced.
